logic_gate_checker: RTL
=======================

LOGIC_GATE_CHECKER -- requirements
Module: logic_gate_checker

Interface
REQ-001 Parameter: TRUTH, default 4'b1000, expected Q per vector index (bit i = expected Q for index i; default is AND).
REQ-002 Parameter: SETTLE_CYCLES, default 2, range 1..15, cycles A/B are held before Q is sampled.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  begins a check run when sampled high in IDLE or DONE.
REQ-006 Port: q_in  input  1  output of the gate under test.
REQ-007 Port: a_out  output  1  A stimulus to the gate under test.
REQ-008 Port: b_out  output  1  B stimulus to the gate under test.
REQ-009 Port: busy  output  1  high while a run is in progress (SETTLE or SAMPLE).
REQ-010 Port: done  output  1  high while in DONE.
REQ-011 Port: pass  output  1  high in DONE when err_count is 0.
REQ-012 Port: err_count  output  3  number of mismatching vectors in the last run, 0..4.

Function
REQ-013 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE, held in a registered state variable.
REQ-014 Vector index idx SHALL be 2 bits; a_out = idx[0], b_out = idx[1], giving the order 00, 10, 01, 11 (A,B).
REQ-015 IDLE/DONE with start=1 -> SETTLE next cycle; idx=0, err_count=0, settle counter=0 loaded on that edge.
REQ-016 SETTLE SHALL increment the settle counter each cycle and go to SAMPLE when counter = SETTLE_CYCLES-1.
REQ-017 SAMPLE SHALL last exactly one cycle and compare q_in against TRUTH[idx]; on mismatch err_count increments, saturating at 4.
REQ-018 SAMPLE with idx<3 -> SETTLE with idx+1 and counter cleared; SAMPLE with idx=3 -> DONE, idx held at 3.
REQ-019 a_out/b_out SHALL stay constant from the first SETTLE cycle of a vector through its SAMPLE cycle.
REQ-020 Each vector SHALL occupy SETTLE_CYCLES+1 cycles; done SHALL rise 4*(SETTLE_CYCLES+1)+1 cycles after the start edge.
REQ-021 start while busy SHALL be ignored; run continues unchanged.
REQ-022 DONE SHALL hold done, pass and err_count until start (restart) or rst.
REQ-023 In IDLE a_out=b_out=0.

Reset
REQ-024 rst=1 at a rising edge SHALL force state=IDLE, idx=0, settle counter=0, err_count=0, a_out=0, b_out=0, busy=0, done=0, pass=0.
REQ-025 rst SHALL take priority over start and over any in-progress run; a run aborted mid-vector SHALL leave no residual count.
REQ-026 First start after rst deassertion SHALL be accepted in the same cycle rst is low.

Configuration
REQ-027 Macro GATE_CHK_FIRST_FAIL_EN SHALL, when defined, add outputs fail_valid (1 bit) and fail_vec (2 bits).
REQ-028 With the macro: on the first mismatch of a run, fail_valid=1 and fail_vec=idx, held until next start or rst; later mismatches SHALL NOT overwrite it.
REQ-029 With the macro: start and rst SHALL clear fail_valid and fail_vec to 0.
REQ-030 Without the macro: ports fail_valid and fail_vec SHALL not exist and all other behaviour is identical.

Verification
REQ-031 Ideal AND model on q_in, SETTLE_CYCLES=2, start pulse -> a/b sequence 00,10,01,11, each for 3 cycles; done at cycle 13, pass=1, err_count=0.
REQ-032 q_in tied to 0, TRUTH=4'b1000 -> err_count=1, pass=0; with macro fail_valid=1, fail_vec=3.
REQ-033 q_in tied to 1 -> err_count=3, pass=0; with macro fail_vec=0 (first failure), not overwritten.
REQ-034 rst asserted during vector 2 SETTLE -> next cycle all outputs 0, state IDLE; a new start gives a full clean run with pass=1.
REQ-035 start re-pulsed while busy -> sequence and done timing unchanged; start in DONE -> err_count cleared and new run begins.
REQ-036 TRUTH=4'b1110 (OR) with ideal OR model, SETTLE_CYCLES=1 -> done at cycle 9, pass=1.

Source files
------------

// File: rtl/logic_gate_checker.sv
// Exhaustive two-input gate checker: walks A/B through 00,10,01,11, samples q_in after a settle
// delay and counts mismatches against TRUTH. Define GATE_CHK_FIRST_FAIL_EN for first-failure capture.
module logic_gate_checker #(
   parameter logic [3:0]  TRUTH         = 4'b1000,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       q_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count
`ifdef GATE_CHK_FIRST_FAIL_EN
   ,
   output logic       fail_valid,
   output logic [1:0] fail_vec
`endif
);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

   state_e     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] err_q, err_d;
   logic       accept;
   logic       mismatch;

   assign accept   = start && (state_q == StIdle || state_q == StDone);
   assign mismatch = (state_q == StSample) && (q_in != TRUTH[idx_q]);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StSettle;
               idx_d   = 2'd0;
               cnt_d   = 4'd0;
               err_d   = 3'd0;
            end
         end
         StSettle: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == SettleLast) state_d = StSample;
         end
         StSample: begin
            if (mismatch && err_q != 3'd4) err_d = err_q + 3'd1;
            if (idx_q == 2'd3) begin
               state_d = StDone;
            end else begin
               state_d = StSettle;
               idx_d   = idx_q + 2'd1;
               cnt_d   = 4'd0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 2'd0;
         cnt_q   <= 4'd0;
         err_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // idx is zero in IDLE, so A/B need no extra gating there
   assign a_out     = idx_q[0];
   assign b_out     = idx_q[1];
   assign busy      = (state_q == StSettle) || (state_q == StSample);
   assign done      = (state_q == StDone);
   assign pass      = done && (err_q == 3'd0);
   assign err_count = err_q;

`ifdef GATE_CHK_FIRST_FAIL_EN
   logic       fail_valid_q, fail_valid_d;
   logic [1:0] fail_vec_q, fail_vec_d;

   always_comb begin
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      if (accept) begin
         fail_valid_d = 1'b0;
         fail_vec_d   = 2'd0;
      end else if (mismatch && !fail_valid_q) begin
         fail_valid_d = 1'b1;
         fail_vec_d   = idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_valid_q <= 1'b0;
         fail_vec_q   <= 2'd0;
      end else begin
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
      end
   end

   assign fail_valid = fail_valid_q;
   assign fail_vec   = fail_vec_q;
`else
   logic unused_accept;
   assign unused_accept = accept;
`endif

endmodule
